// File: rtl/dcache_sram_sched_pkg.sv
// Shared types and sizing helpers for the data-cache SRAM scheduler.
package dcache_sram_sched_pkg;

  typedef enum logic {
    INIT = 1'b0,
    ARB  = 1'b1
  } sched_state_e;

  localparam int unsigned DEF_INDEX_WIDTH  = 12;
  localparam int unsigned DEF_BYTE_OFFSET  = 4;
  localparam int unsigned DEF_STARVE_LIMIT = 15;
  localparam int unsigned NUM_WORDS        = 2 ** (DEF_INDEX_WIDTH - DEF_BYTE_OFFSET);

  function automatic int unsigned num_words(input int unsigned index_w, input int unsigned byte_off);
    return 32'd1 << (index_w - byte_off);
  endfunction

endpackage

// File: rtl/dcache_sram_sched_lzc.sv
// Trailing-zero counter: index of the lowest set bit, plus an all-zero flag.
module dcache_sram_sched_lzc #(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_in,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_empty
);

  // Scan from the top so the lowest set bit is the last one to land.
  always_comb begin
    o_cnt = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      o_cnt = i_in[i] ? CNT_W'(i) : o_cnt;
    end
    o_empty = ~|i_in;
  end

endmodule

// File: rtl/dcache_sram_sched.sv
// Shared SRAM access scheduler with aging-based starvation avoidance and a
// zero-fill sweep of every set after reset or on request.
module dcache_sram_sched
  import dcache_sram_sched_pkg::*;
#(
  parameter int unsigned NR_PORTS     = 4,
  parameter int unsigned SET_ASSOC    = 8,
  parameter int unsigned INDEX_WIDTH  = DEF_INDEX_WIDTH,
  parameter int unsigned BYTE_OFFSET  = DEF_BYTE_OFFSET,
  parameter int unsigned CL_W         = 176,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            init_req_i,
  input  logic [NR_PORTS*SET_ASSOC-1:0]   req_i,
  input  logic [NR_PORTS*INDEX_WIDTH-1:0] addr_i,
  input  logic [NR_PORTS-1:0]             we_i,
  input  logic [NR_PORTS*CL_W-1:0]        wdata_i,
  input  logic [NR_PORTS*CL_W-1:0]        be_i,
  output logic [NR_PORTS-1:0]             gnt_o,
  output logic [NR_PORTS-1:0]             rvalid_o,
  output logic [SET_ASSOC-1:0]            ram_req_o,
  output logic [INDEX_WIDTH-1:0]          ram_addr_o,
  output logic                            ram_we_o,
  output logic [CL_W-1:0]                 ram_wdata_o,
  output logic [CL_W-1:0]                 ram_be_o,
  output logic                            busy_o,
  output logic                            init_done_o
);

  localparam int unsigned NW    = num_words(INDEX_WIDTH, BYTE_OFFSET);
  localparam int unsigned IDX_W = INDEX_WIDTH - BYTE_OFFSET;
  localparam int unsigned PW    = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  localparam int unsigned AW    = $clog2(STARVE_LIMIT + 1);

  sched_state_e        r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [AW-1:0]       r_age [NR_PORTS];
  logic [NR_PORTS-1:0] r_rvalid;
  logic                r_init_done;

  logic [NR_PORTS-1:0] w_active;
  logic [NR_PORTS-1:0] w_starving;
  logic [NR_PORTS-1:0] w_gnt;
  logic [PW-1:0]       w_act_idx;
  logic [PW-1:0]       w_stv_idx;
  logic [PW-1:0]       w_win;
  logic                w_act_empty;
  logic                w_stv_empty;
  logic                w_grant_any;

  // Activity and starvation flags per requester.
  always_comb begin
    for (int p = 0; p < NR_PORTS; p++) begin
      w_active[p]   = |req_i[p*SET_ASSOC +: SET_ASSOC];
      w_starving[p] = w_active[p] && (r_age[p] == AW'(STARVE_LIMIT));
    end
  end

  dcache_sram_sched_lzc #(.WIDTH(NR_PORTS)) u_lzc_active (
    .i_in    (w_active),
    .o_cnt   (w_act_idx),
    .o_empty (w_act_empty)
  );

  dcache_sram_sched_lzc #(.WIDTH(NR_PORTS)) u_lzc_starving (
    .i_in    (w_starving),
    .o_cnt   (w_stv_idx),
    .o_empty (w_stv_empty)
  );

  assign w_win       = w_stv_empty ? w_act_idx : w_stv_idx;
  assign w_grant_any = !rst_i && (r_state == ARB) && !w_act_empty;
  assign w_gnt       = w_grant_any ? (NR_PORTS'(1) << w_win) : '0;

  // SRAM bus: sweep pattern while initialising, otherwise the arbitration winner.
  always_comb begin
    if (rst_i) begin
      ram_req_o   = '0;
      ram_addr_o  = '0;
      ram_we_o    = 1'b0;
      ram_wdata_o = '0;
      ram_be_o    = '0;
    end else if (r_state == INIT) begin
      ram_req_o   = '1;
      ram_addr_o  = {r_idx, {BYTE_OFFSET{1'b0}}};
      ram_we_o    = 1'b1;
      ram_wdata_o = '0;
      ram_be_o    = '1;
    end else if (w_grant_any) begin
      ram_req_o   = req_i[w_win*SET_ASSOC +: SET_ASSOC];
      ram_addr_o  = addr_i[w_win*INDEX_WIDTH +: INDEX_WIDTH];
      ram_we_o    = we_i[w_win];
      ram_wdata_o = wdata_i[w_win*CL_W +: CL_W];
      ram_be_o    = be_i[w_win*CL_W +: CL_W];
    end else begin
      ram_req_o   = '0;
      ram_addr_o  = '0;
      ram_we_o    = 1'b0;
      ram_wdata_o = '0;
      ram_be_o    = '0;
    end
  end

  // Sweep/arbitration FSM, age counters and read-valid pipeline.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= INIT;
      r_idx       <= '0;
      r_rvalid    <= '0;
      r_init_done <= 1'b0;
      for (int p = 0; p < NR_PORTS; p++) begin
        r_age[p] <= '0;
      end
    end else begin
      r_rvalid <= w_gnt & ~we_i;
      for (int p = 0; p < NR_PORTS; p++) begin
        if (w_active[p] && !w_gnt[p]) begin
          r_age[p] <= (r_age[p] == AW'(STARVE_LIMIT)) ? r_age[p] : r_age[p] + AW'(1);
        end else begin
          r_age[p] <= '0;
        end
      end
      case (r_state)
        INIT: begin
          r_idx <= r_idx + IDX_W'(1);
          if (r_idx == IDX_W'(NW - 1)) begin
            r_state     <= ARB;
            r_init_done <= 1'b1;
          end
        end
        ARB: begin
          if (init_req_i) begin
            r_state <= INIT;
            r_idx   <= '0;
          end
        end
        default: begin
          r_state <= INIT;
          r_idx   <= '0;
        end
      endcase
    end
  end

  assign gnt_o       = w_gnt;
  assign rvalid_o    = r_rvalid;
  assign busy_o      = (r_state == INIT);
  assign init_done_o = r_init_done;

endmodule
